// File: rtl/seg7_decodificador.sv
// seg7_decodificador: recovers hex digits from a multiplexed active-low 4-digit 7-segment bus.
// Optional SEG7_DEC_CONTEO_ERR_EN adds errores_o, a saturating count of error_o pulses.
module seg7_decodificador #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  anodos_i,
    input  logic [7:0]  segmentos_i,
    output logic [15:0] digitos_o,
    output logic [3:0]  valido_o,
    output logic [3:0]  punto_o,
    output logic        error_o,
    output logic        frame_o
`ifdef SEG7_DEC_CONTEO_ERR_EN
    ,output logic [7:0] errores_o
`endif
);
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] count, count_n;
    logic [3:0]       s_an, p_an, seen, seen_n;
    logic [7:0]       s_seg, p_seg;
    logic [1:0]       idx;
    logic             one_hot, same, capture, legal, blank;
    logic [3:0]       value;

    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b0000001: decode = 5'h10;
            7'b1001111: decode = 5'h11;
            7'b0010010: decode = 5'h12;
            7'b0000110: decode = 5'h13;
            7'b1001100: decode = 5'h14;
            7'b0100100: decode = 5'h15;
            7'b0100000: decode = 5'h16;
            7'b0001111: decode = 5'h17;
            7'b0000000: decode = 5'h18;
            7'b0000100: decode = 5'h19;
            7'b0001000: decode = 5'h1A;
            7'b1100000: decode = 5'h1B;
            7'b0110001: decode = 5'h1C;
            7'b1000010: decode = 5'h1D;
            7'b0110000: decode = 5'h1E;
            7'b0111000: decode = 5'h1F;
            default:    decode = 5'h00;
        endcase
    endfunction

    always_comb begin
        one_hot = (s_an == 4'b1110) || (s_an == 4'b1101) || (s_an == 4'b1011) || (s_an == 4'b0111);
        same    = (s_an == p_an) && (s_seg == p_seg);
        idx     = !s_an[0] ? 2'd0 : !s_an[1] ? 2'd1 : !s_an[2] ? 2'd2 : 2'd3;
        {legal, value} = decode(s_seg[7:1]);
        blank   = s_seg[7:1] == 7'h7F;
        seen_n  = seen | (4'b0001 << idx);
    end

    always_comb begin
        state_n = state;
        count_n = count;
        if (!one_hot) begin
            state_n = IDLE;
            count_n = '0;
        end else if (state == SETTLE && same) begin
            count_n = (&count) ? count : count + 1'b1;
        end else if (!(state == HOLD && same)) begin
            state_n = SETTLE;
            count_n = CNT_W'(1);
        end
        // Reaching the threshold captures once and parks in HOLD until the pair changes
        capture = (state_n == SETTLE) && (count_n == CNT_W'(STABLE_CYCLES));
        if (capture) state_n = HOLD;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s_an      <= 4'hF;
            p_an      <= 4'hF;
            s_seg     <= 8'hFF;
            p_seg     <= 8'hFF;
            state     <= IDLE;
            count     <= '0;
            seen      <= 4'h0;
            digitos_o <= 16'h0000;
            valido_o  <= 4'h0;
            punto_o   <= 4'h0;
            error_o   <= 1'b0;
            frame_o   <= 1'b0;
        end else begin
            s_an    <= anodos_i;
            s_seg   <= segmentos_i;
            p_an    <= s_an;
            p_seg   <= s_seg;
            state   <= state_n;
            count   <= count_n;
            error_o <= 1'b0;
            frame_o <= 1'b0;
            if (capture) begin
                valido_o[idx] <= legal;
                if (legal) digitos_o[{idx, 2'b00} +: 4] <= value;
                if (legal || blank) punto_o[idx] <= ~s_seg[0];
                if (!legal && !blank) error_o <= 1'b1;
                frame_o <= seen_n == 4'hF;
                seen    <= (seen_n == 4'hF) ? 4'h0 : seen_n;
            end
        end
    end

`ifdef SEG7_DEC_CONTEO_ERR_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) errores_o <= 8'h00;
        else if (capture && !legal && !blank && errores_o != 8'hFF) errores_o <= errores_o + 8'h01;
    end
`endif
endmodule

// File: tb/tb_seg7_decodificador.sv
// tb_seg7_decodificador: randomized and directed checks of seg7_decodificador against a run-length model.
module tb_seg7_decodificador;
    localparam int N = 4;
    localparam logic [6:0] TBL [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    logic        clk = 1'b0, rst = 1'b1;
    logic [3:0]  anodos = 4'hF;
    logic [7:0]  segmentos = 8'hFF;
    logic [15:0] digitos;
    logic [3:0]  valido, punto;
    logic        error, frame;
    int checks = 0, fails = 0, frame_cnt = 0, err_cnt = 0;
`ifdef SEG7_DEC_CONTEO_ERR_EN
    logic [7:0] errores;
`endif

    seg7_decodificador #(.STABLE_CYCLES(N), .CNT_W(8)) dut (
        .clk_i(clk), .rst_i(rst), .anodos_i(anodos), .segmentos_i(segmentos),
        .digitos_o(digitos), .valido_o(valido), .punto_o(punto),
        .error_o(error), .frame_o(frame)
`ifdef SEG7_DEC_CONTEO_ERR_EN
        , .errores_o(errores)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_one_hot(input logic [3:0] a);
        return a inside {4'b1110, 4'b1101, 4'b1011, 4'b0111};
    endfunction

    function automatic int lookup(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (TBL[i] == p) return i;
        return -1;
    endfunction

    // Reference: capture whenever the last N accepted samples form one identical one-hot run
    logic [3:0] md [4];
    logic [3:0] mv, mp, mseen;
    logic       merr, mframe, started = 1'b0;
    logic [7:0] mcnt;
    logic [3:0] pa;
    logic [7:0] ps;
    int run = 0;

    always @(posedge clk) begin
        merr = 1'b0;
        mframe = 1'b0;
        if (rst) begin
            for (int i = 0; i < 4; i++) md[i] = 4'h0;
            mv = 4'h0; mp = 4'h0; mseen = 4'h0; mcnt = 8'h00;
            run = 0;
            started = 1'b1;
        end else begin
            if (run == N) begin
                int n, v;
                n = !pa[0] ? 0 : !pa[1] ? 1 : !pa[2] ? 2 : 3;
                v = lookup(ps[7:1]);
                if (v >= 0) begin
                    md[n] = 4'(v); mv[n] = 1'b1; mp[n] = ~ps[0];
                end else if (ps[7:1] == 7'h7F) begin
                    mv[n] = 1'b0; mp[n] = ~ps[0];
                end else begin
                    mv[n] = 1'b0; merr = 1'b1;
                    if (mcnt != 8'hFF) mcnt++;
                end
                mseen[n] = 1'b1;
                if (mseen == 4'hF) begin mframe = 1'b1; mseen = 4'h0; end
            end
            if (is_one_hot(anodos)) run = (run > 0 && anodos == pa && segmentos == ps) ? run + 1 : 1;
            else run = 0;
            pa = anodos;
            ps = segmentos;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("cycle", {digitos, valido, punto, error, frame},
                  {md[3], md[2], md[1], md[0], mv, mp, merr, mframe});
`ifdef SEG7_DEC_CONTEO_ERR_EN
            check("errores", errores, mcnt);
`endif
            frame_cnt += frame;
            err_cnt += error;
        end
    end

    task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
        anodos = a;
        segmentos = s;
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] rand_illegal();
        logic [6:0] p;
        do p = 7'($urandom); while (lookup(p) >= 0 || p == 7'h7F);
        return {p, 1'($urandom)};
    endfunction

    initial begin
        int f0, e0;
        logic [15:0] d0;
        logic [3:0] v0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        hold(4'b1110, 8'b00100101, N);
        check("latency_before", valido, 4'h0);
        hold(4'b1110, 8'b00100101, 1);
        check("digit0_value", digitos, 16'h0002);
        check("digit0_valid", valido, 4'b0001);
        check("digit0_point", punto, 4'h0);
        hold(4'b1110, 8'b00100101, 5);
        check("no_error_t1", err_cnt, 0);

        f0 = frame_cnt;
        hold(4'b1110, 8'b00010001, 6);
        hold(4'b1101, 8'b11000001, 6);
        hold(4'b1011, 8'b01100011, 6);
        hold(4'b0111, 8'b10000101, 6);
        check("frame_digits", digitos, 16'hDCBA);
        check("frame_valid", valido, 4'hF);
        check("frame_pulses", frame_cnt - f0, 1);

        e0 = err_cnt;
        hold(4'b1101, 8'b11111110, 6);
        check("blank_valid", valido[1], 1'b0);
        check("blank_point", punto[1], 1'b1);
        check("blank_noerr", err_cnt - e0, 0);

        hold(4'b1011, 8'b10101011, 6);
        check("illegal_err", err_cnt - e0, 1);
        check("illegal_valid", valido[2], 1'b0);
`ifdef SEG7_DEC_CONTEO_ERR_EN
        check("illegal_count", errores, 8'd1);
`endif

        d0 = digitos; v0 = valido; e0 = err_cnt;
        hold(4'b1110, 8'b00000001, 3);
        hold(4'b1100, 8'b00000001, 6);
        check("glitch_digits", digitos, d0);
        check("glitch_valid", valido, v0);
        check("glitch_noerr", err_cnt - e0, 0);

        hold(4'b1110, 8'b01001001, 3);
        rst = 1'b1;
        @(negedge clk);
        check("reset_outputs", {digitos, valido, punto, error, frame}, 26'h0);
        rst = 1'b0;
        repeat (N) @(negedge clk);
        check("reset_fresh_wait", valido, 4'h0);
        @(negedge clk);
        check("reset_fresh_cap", {digitos, valido}, {16'h0005, 4'b0001});

        for (int it = 0; it < 250; it++) begin
            int k;
            logic [3:0] a;
            logic [7:0] s;
            k = $urandom_range(0, 9);
            a = 4'b1111 ^ (4'b0001 << $urandom_range(0, 3));
            s = {TBL[$urandom_range(0, 15)], 1'($urandom)};
            if (k == 7) s = {7'h7F, 1'($urandom)};
            if (k == 8) s = rand_illegal();
            if (k == 9) a = $urandom_range(0, 1) ? 4'b1111 : (4'b0000 | 4'($urandom_range(0, 3)));
            if ($urandom_range(0, 29) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            hold(a, s, $urandom_range(1, 7));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
